// File: rtl/user_obi_timer.sv
// OBI subordinate timer: 32-bit up-counter with compare match, auto-reload and level irq.
// Optional divider at offset 0x10 is enabled by defining USER_OBI_TIMER_PRESCALER_EN.
module user_obi_timer #(
  parameter int unsigned IdWidth    = 1,
  parameter logic [31:0] RspErrData = 32'hBADCAB1E
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               obi_req_i,
  output logic               obi_gnt_o,
  input  logic [31:0]        obi_addr_i,
  input  logic               obi_we_i,
  input  logic [3:0]         obi_be_i,
  input  logic [31:0]        obi_wdata_i,
  input  logic [IdWidth-1:0] obi_aid_i,
  output logic               obi_rvalid_o,
  output logic [31:0]        obi_rdata_o,
  output logic               obi_err_o,
  output logic [IdWidth-1:0] obi_rid_o,
  output logic               irq_o
);

  typedef enum logic [2:0] {
    RegCtrl    = 3'd0,
    RegCount   = 3'd1,
    RegCompare = 3'd2,
    RegStatus  = 3'd3,
    RegPresc   = 3'd4
  } reg_e;

  logic [2:0]  sel;
  logic        mapped, wr_en, tick, hit;
  logic [31:0] wmask;

  logic        en_q, irq_en_q, reload_q, match_q, irq_q;
  logic        en_d, irq_en_d, reload_d, match_d;
  logic [31:0] count_q, compare_q, count_d, compare_d;

  logic               rvalid_q, err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [IdWidth-1:0] rid_q;

`ifdef USER_OBI_TIMER_PRESCALER_EN
  logic [7:0] presc_q, presc_d, div_q, div_d;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{obi_addr_i[31:5], obi_addr_i[1:0]};

  assign obi_gnt_o    = obi_req_i;
  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = rdata_q;
  assign obi_err_o    = err_q;
  assign obi_rid_o    = rid_q;
  assign irq_o        = irq_q;

  always_comb begin
    sel   = obi_addr_i[4:2];
    wmask = {{8{obi_be_i[3]}}, {8{obi_be_i[2]}}, {8{obi_be_i[1]}}, {8{obi_be_i[0]}}};
`ifdef USER_OBI_TIMER_PRESCALER_EN
    mapped = (sel <= RegPresc);
    tick   = en_q && (div_q == presc_q);
`else
    mapped = (sel <= RegStatus);
    tick   = en_q;
`endif
    wr_en = obi_req_i && obi_we_i && mapped;
    hit   = tick && (count_q == compare_q);

    en_d      = en_q;
    irq_en_d  = irq_en_q;
    reload_d  = reload_q;
    count_d   = count_q;
    compare_d = compare_q;
    match_d   = match_q;
`ifdef USER_OBI_TIMER_PRESCALER_EN
    presc_d = presc_q;
    div_d   = (!en_q || tick) ? '0 : div_q + 8'd1;
`endif

    // Hardware update first; a software write below overrides it in the same cycle.
    if (tick) begin
      if (hit) begin
        if (reload_q) count_d = '0;
        else          en_d    = 1'b0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (wr_en) begin
      case (sel)
        RegCtrl: if (obi_be_i[0]) {reload_d, irq_en_d, en_d} = obi_wdata_i[2:0];
        RegCount: if (|obi_be_i) count_d = (count_q & ~wmask) | (obi_wdata_i & wmask);
        RegCompare: compare_d = (compare_q & ~wmask) | (obi_wdata_i & wmask);
        RegStatus: if (obi_be_i[0] && obi_wdata_i[0]) match_d = 1'b0;
`ifdef USER_OBI_TIMER_PRESCALER_EN
        RegPresc: begin
          if (obi_be_i[0]) presc_d = obi_wdata_i[7:0];
          div_d = '0;
        end
`endif
        default: ;
      endcase
    end

    if (hit) match_d = 1'b1;

    rdata_d = '0;
    err_d   = 1'b0;
    if (obi_req_i) begin
      if (!mapped) begin
        err_d   = 1'b1;
        rdata_d = RspErrData;
      end else if (!obi_we_i) begin
        case (sel)
          RegCtrl:    rdata_d = {29'd0, reload_q, irq_en_q, en_q};
          RegCount:   rdata_d = count_q;
          RegCompare: rdata_d = compare_q;
          RegStatus:  rdata_d = {31'd0, match_q};
`ifdef USER_OBI_TIMER_PRESCALER_EN
          RegPresc:   rdata_d = {24'd0, presc_q};
`endif
          default:    rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      reload_q  <= 1'b0;
      match_q   <= 1'b0;
      irq_q     <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rid_q     <= '0;
`ifdef USER_OBI_TIMER_PRESCALER_EN
      presc_q   <= '0;
      div_q     <= '0;
`endif
    end else begin
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      reload_q  <= reload_d;
      match_q   <= match_d;
      irq_q     <= match_q & irq_en_q;
      count_q   <= count_d;
      compare_q <= compare_d;
      rvalid_q  <= obi_req_i;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rid_q     <= obi_req_i ? obi_aid_i : rid_q;
`ifdef USER_OBI_TIMER_PRESCALER_EN
      presc_q   <= presc_d;
      div_q     <= div_d;
`endif
    end
  end

endmodule

// File: tb/tb_user_obi_timer.sv
// Self-checking bench for user_obi_timer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural timer model.
module tb_user_obi_timer;

  localparam logic [31:0] ERR_DATA = 32'hBADCAB1E;
`ifdef USER_OBI_TIMER_PRESCALER_EN
  localparam int unsigned NMAP = 5;
`else
  localparam int unsigned NMAP = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n, req, we, aid;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt, rvalid, err, rid, irq;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  user_obi_timer #(
    .IdWidth   (1),
    .RspErrData(ERR_DATA)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .obi_req_i   (req),
    .obi_gnt_o   (gnt),
    .obi_addr_i  (addr),
    .obi_we_i    (we),
    .obi_be_i    (be),
    .obi_wdata_i (wdata),
    .obi_aid_i   (aid),
    .obi_rvalid_o(rvalid),
    .obi_rdata_o (rdata),
    .obi_err_o   (err),
    .obi_rid_o   (rid),
    .irq_o       (irq)
  );

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: timer state as plain variables, advanced once per clock edge.
  bit          m_en, m_ie, m_ar, m_match;
  logic [31:0] m_count, m_cmp;
  logic [7:0]  m_presc, m_div;
  bit          e_rvalid, e_err, e_irq;
  logic        e_rid;
  logic [31:0] e_rdata;
  int unsigned off;
  bit          is_map, is_wr, m_tick, at_cmp, clr;
  logic [31:0] n_count;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] ben);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (ben[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int unsigned o);
    case (o)
      0: return {29'd0, m_ar, m_ie, m_en};
      1: return m_count;
      2: return m_cmp;
      3: return {31'd0, m_match};
      4: return {24'd0, m_presc};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      {m_en, m_ie, m_ar, m_match} = '0;
      m_count = '0; m_cmp = '0; m_presc = '0; m_div = '0;
      e_rvalid = 0; e_err = 0; e_irq = 0; e_rid = 0; e_rdata = '0;
    end else begin
      off    = int'(addr[4:2]);
      is_map = off < NMAP;
      is_wr  = req && we && is_map;
`ifdef USER_OBI_TIMER_PRESCALER_EN
      m_tick = m_en && (m_div == m_presc);
`else
      m_tick = m_en;
`endif
      at_cmp = m_tick && (m_count == m_cmp);

      e_rvalid = req;
      if (req) e_rid = aid;
      e_err    = req && !is_map;
      e_rdata  = !req ? 32'd0 : !is_map ? ERR_DATA : we ? 32'd0 : model_read(off);
      e_irq    = m_match && m_ie;

      if (at_cmp)      n_count = m_ar ? 32'd0 : m_count;
      else if (m_tick) n_count = m_count + 1;
      else             n_count = m_count;
      clr     = is_wr && off == 3 && be[0] && wdata[0];
      m_match = at_cmp || (m_match && !clr);
      m_div   = (!m_en || m_tick) ? 8'd0 : m_div + 1;
      if (at_cmp && !m_ar) m_en = 0;

      if (is_wr && off == 0 && be[0]) {m_ar, m_ie, m_en} = wdata[2:0];
      if (is_wr && off == 1 && be != 0) n_count = merge(m_count, wdata, be);
      if (is_wr && off == 2) m_cmp = merge(m_cmp, wdata, be);
      if (is_wr && off == 4) begin
        if (be[0]) m_presc = wdata[7:0];
        m_div = 0;
      end
      m_count = n_count;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("gnt", {31'd0, gnt}, {31'd0, req});
      check("irq", {31'd0, irq}, {31'd0, e_irq});
      check("rvalid", {31'd0, rvalid}, {31'd0, e_rvalid});
      if (e_rvalid) begin
        check("rdata", rdata, e_rdata);
        check("err", {31'd0, err}, {31'd0, e_err});
        check("rid", {31'd0, rid}, {31'd0, e_rid});
      end
    end
  end

  task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, input logic id,
                     output logic [31:0] rd, output logic er, output logic rv, output logic ri);
    req = 1'b1; we = w; addr = a; be = b; wdata = d; aid = id;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    rd = rdata; er = err; rv = rvalid; ri = rid;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] rd; logic er, rv, ri;
    bus(1'b1, a, b, d, 1'b0, rd, er, rv, ri);
  endtask

  task automatic rd_expect(input string name, input logic [31:0] a,
                           input logic [31:0] exp, input logic exp_err);
    logic [31:0] rd; logic er, rv, ri;
    bus(1'b0, a, 4'hF, 32'd0, 1'b1, rd, er, rv, ri);
    check({name, "_rvalid"}, {31'd0, rv}, 32'd1);
    check({name, "_rid"}, {31'd0, ri}, 32'd1);
    check({name, "_err"}, {31'd0, er}, {31'd0, exp_err});
    check(name, rd, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] seq_ar [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`ifdef USER_OBI_TIMER_PRESCALER_EN
  logic [31:0] seq_pr [7] = '{0, 0, 0, 1, 1, 1, 2};
`endif

  initial begin
    logic [31:0] rd; logic er, rv, ri;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; aid = 1'b0;
    @(posedge clk); #1;
    chk_on = 1'b1;
    idle(2);
    rst_n = 1'b1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);

    rd_expect("rst_ctrl", 32'h00, 32'd0, 1'b0);
    rd_expect("rst_count", 32'h04, 32'd0, 1'b0);
    rd_expect("rst_compare", 32'h08, 32'd0, 1'b0);
    rd_expect("rst_status", 32'h0C, 32'd0, 1'b0);

    // One-shot compare with irq
    wr(32'h08, 32'd5, 4'hF);
    wr(32'h00, 32'h3, 4'hF);
    idle(10);
    check("oneshot_irq", {31'd0, irq}, 32'd1);
    rd_expect("oneshot_count", 32'h04, 32'd5, 1'b0);
    rd_expect("oneshot_ctrl", 32'h00, 32'h2, 1'b0);
    rd_expect("oneshot_status", 32'h0C, 32'd1, 1'b0);
    wr(32'h0C, 32'd1, 4'hF);
    check("w1c_irq_lag", {31'd0, irq}, 32'd1);
    idle(1);
    check("w1c_irq_clr", {31'd0, irq}, 32'd0);

    // Auto-reload without irq
    wr(32'h00, 32'd0, 4'hF);
    wr(32'h04, 32'd0, 4'hF);
    wr(32'h08, 32'd3, 4'hF);
    wr(32'h00, 32'h5, 4'hF);
    for (int i = 0; i < 8; i++) rd_expect("reload_seq", 32'h04, seq_ar[i], 1'b0);
    rd_expect("reload_status", 32'h0C, 32'd1, 1'b0);
    check("reload_irq", {31'd0, irq}, 32'd0);
    wr(32'h00, 32'd0, 4'hF);

    // Unmapped offset
    rd_expect("unmapped_rd", 32'h18, ERR_DATA, 1'b1);
    bus(1'b1, 32'h18, 4'hF, 32'hFFFF_FFFF, 1'b0, rd, er, rv, ri);
    check("unmapped_wr_err", {31'd0, er}, 32'd1);
    rd_expect("unmapped_nochg", 32'h08, 32'd3, 1'b0);

    // Byte enables and wrap
    wr(32'h0C, 32'd1, 4'hF);
    wr(32'h08, 32'h10, 4'hF);
    wr(32'h08, 32'hAAAA, 4'h0);
    rd_expect("be0_noop", 32'h08, 32'h10, 1'b0);
    wr(32'h04, 32'd0, 4'hF);
    wr(32'h04, 32'hFFFF_FFFF, 4'b0001);
    rd_expect("be_lowbyte", 32'h04, 32'h0000_00FF, 1'b0);
    wr(32'h04, 32'hFFFF_FFFF, 4'hF);
    wr(32'h00, 32'h1, 4'hF);
    rd_expect("wrap_pre", 32'h04, 32'hFFFF_FFFF, 1'b0);
    rd_expect("wrap_zero", 32'h04, 32'd0, 1'b0);
    rd_expect("wrap_nomatch", 32'h0C, 32'd0, 1'b0);

    // Match set and W1C in the same cycle: set wins
    wr(32'h00, 32'd0, 4'hF);
    wr(32'h04, 32'd0, 4'hF);
    wr(32'h08, 32'd2, 4'hF);
    wr(32'h00, 32'h1, 4'hF);
    idle(2);
    wr(32'h0C, 32'd1, 4'hF);
    rd_expect("set_beats_clr", 32'h0C, 32'd1, 1'b0);
    wr(32'h00, 32'd0, 4'hF);
    wr(32'h0C, 32'd1, 4'hF);

`ifdef USER_OBI_TIMER_PRESCALER_EN
    wr(32'h08, 32'hFFFF, 4'hF);
    wr(32'h04, 32'd0, 4'hF);
    wr(32'h10, 32'd2, 4'hF);
    wr(32'h00, 32'h1, 4'hF);
    for (int i = 0; i < 7; i++) rd_expect("presc_seq", 32'h04, seq_pr[i], 1'b0);
    rd_expect("presc_rd", 32'h10, 32'd2, 1'b0);
    wr(32'h00, 32'd0, 4'hF);
`else
    rd_expect("presc_unmapped", 32'h10, ERR_DATA, 1'b1);
`endif

    // Randomized traffic including occasional mid-transaction resets
    for (int c = 0; c < 4000; c++) begin
      int unsigned o;
      rst_n = ($urandom_range(0, 299) != 0);
      req   = ($urandom_range(0, 9) < 7);
      we    = $urandom_range(0, 1);
      o     = ($urandom_range(0, 7) < 6) ? $urandom_range(0, 4) : $urandom_range(5, 7);
      addr  = {$urandom} & 32'hFFFF_FFE3 | (o << 2);
      be    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      aid   = $urandom_range(0, 1);
      case (o)
        1, 2:    wdata = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 40);
        4:       wdata = $urandom_range(0, 3);
        default: wdata = $urandom;
      endcase
      @(posedge clk); #1;
    end
    rst_n = 1'b1; req = 1'b0; we = 1'b0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
